// File: rtl/fi_recovery_ctrl.sv
// fi_recovery_ctrl
// Recovery sequencer behind the fault-injection commit checker. On a
// propagated fault, an unexpected syscall or a hung core (braindead
// watchdog) it waits for the store queue to drain, forces an exception at
// the continue PC, requests an architectural-state restore and then returns
// to normal operation. Every output is a flop, so no input reaches an
// output combinationally.

module fi_recovery_ctrl #(
    parameter int SIZE_PC         = 32,
    parameter int STQ_CNT_W       = 5,
    parameter int WATCHDOG_CYCLES = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 commitValid,
    input  logic [SIZE_PC-1:0]   commitNextPC,
    input  logic                 faultPropagated,
    input  logic                 unexpectedSyscall,
    input  logic [STQ_CNT_W-1:0] stqCount,
    input  logic                 exceptionAck,
    input  logic                 restoreDone,
    output logic                 forceException,
    output logic [SIZE_PC-1:0]   exceptionPC,
    output logic                 restoreReq,
    output logic                 stallFetch,
    output logic                 busy,
    output logic [1:0]           cause,
    output logic [15:0]          recoveryCnt,
    output logic [7:0]           droppedCnt
);

    localparam int WD_W = $clog2(WATCHDOG_CYCLES);

    // The trigger is taken in the cycle whose increment would bring the
    // counter to WATCHDOG_CYCLES-1, so DRAIN starts exactly WATCHDOG_CYCLES
    // cycles after the last commit cycle.
    localparam logic [WD_W-1:0] WD_FIRE = WD_W'(WATCHDOG_CYCLES - 2);

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_FAULT   = 2'd1;
    localparam logic [1:0] CAUSE_BRAIN   = 2'd2;
    localparam logic [1:0] CAUSE_SYSCALL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_RESTORE = 3'd3,
        ST_RESUME  = 3'd4
    } state_t;

    state_t               state_r;
    logic [SIZE_PC-1:0]   arch_pc_r;
    logic [WD_W-1:0]      wd_cnt_r;

    logic                 braindead_s;
    logic                 trig_s;
    logic [1:0]           trig_cause_s;
    logic [SIZE_PC-1:0]   trig_pc_s;
    logic                 drop_s;

    // Trigger decode: priority fault > syscall > braindead, PC selection and drop detect
    always_comb begin
        braindead_s  = 1'b0;
        trig_cause_s = CAUSE_NONE;
        trig_pc_s    = arch_pc_r;
        drop_s       = 1'b0;

        if ((state_r == ST_IDLE) && !commitValid && (wd_cnt_r == WD_FIRE)) begin
            braindead_s = 1'b1;
        end else begin
            braindead_s = 1'b0;
        end

        if (faultPropagated) begin
            trig_cause_s = CAUSE_FAULT;
        end else if (unexpectedSyscall) begin
            trig_cause_s = CAUSE_SYSCALL;
        end else if (braindead_s) begin
            trig_cause_s = CAUSE_BRAIN;
        end else begin
            trig_cause_s = CAUSE_NONE;
        end

        if (commitValid) begin
            trig_pc_s = commitNextPC;
        end else begin
            trig_pc_s = arch_pc_r;
        end

        if ((state_r != ST_IDLE) && (faultPropagated || unexpectedSyscall)) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    assign trig_s = (trig_cause_s != CAUSE_NONE);

    // Architectural PC tracking: follows every commit regardless of state
    always_ff @(posedge clk) begin
        if (reset) begin
            arch_pc_r <= {SIZE_PC{1'b0}};
        end else if (commitValid) begin
            arch_pc_r <= commitNextPC;
        end
    end

    // Braindead watchdog: counts commit-free IDLE cycles, held at zero during recovery
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (commitValid || (state_r != ST_IDLE)) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end
    end

    // Saturating count of triggers that arrive while a recovery is already running
    always_ff @(posedge clk) begin
        if (reset) begin
            droppedCnt <= 8'd0;
        end else if (drop_s && (droppedCnt != 8'hFF)) begin
            droppedCnt <= droppedCnt + 8'd1;
        end
    end

    // Recovery sequencer with registered outputs set on each state transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            busy           <= 1'b0;
            stallFetch     <= 1'b0;
            forceException <= 1'b0;
            restoreReq     <= 1'b0;
            cause          <= CAUSE_NONE;
            exceptionPC    <= {SIZE_PC{1'b0}};
            recoveryCnt    <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (trig_s) begin
                        state_r     <= ST_DRAIN;
                        busy        <= 1'b1;
                        stallFetch  <= 1'b1;
                        cause       <= trig_cause_s;
                        exceptionPC <= trig_pc_s;
                    end
                end
                ST_DRAIN: begin
                    if (stqCount == {STQ_CNT_W{1'b0}}) begin
                        state_r        <= ST_FLUSH;
                        forceException <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (exceptionAck) begin
                        state_r        <= ST_RESTORE;
                        forceException <= 1'b0;
                        restoreReq     <= 1'b1;
                    end
                end
                ST_RESTORE: begin
                    if (restoreDone) begin
                        state_r    <= ST_RESUME;
                        restoreReq <= 1'b0;
                        stallFetch <= 1'b0;
                    end
                end
                ST_RESUME: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    cause   <= CAUSE_NONE;
                    if (recoveryCnt != 16'hFFFF) begin
                        recoveryCnt <= recoveryCnt + 16'd1;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    busy           <= 1'b0;
                    stallFetch     <= 1'b0;
                    forceException <= 1'b0;
                    restoreReq     <= 1'b0;
                    cause          <= CAUSE_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fi_recovery_ctrl.sv
// Testbench for fi_recovery_ctrl: a scoreboard holds the expected cause and
// exception PC of each accepted trigger and is checked when busy rises;
// scenario tasks check timing, counters and reset behaviour inline.

module tb_fi_recovery_ctrl;

    logic        clk;
    logic        reset;
    logic        commitValid;
    logic [31:0] commitNextPC;
    logic        faultPropagated;
    logic        unexpectedSyscall;
    logic [4:0]  stqCount;
    logic        exceptionAck;
    logic        restoreDone;
    logic        forceException;
    logic [31:0] exceptionPC;
    logic        restoreReq;
    logic        stallFetch;
    logic        busy;
    logic [1:0]  cause;
    logic [15:0] recoveryCnt;
    logic [7:0]  droppedCnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  cause;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];

    fi_recovery_ctrl #(
        .SIZE_PC         (32),
        .STQ_CNT_W       (5),
        .WATCHDOG_CYCLES (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .commitValid       (commitValid),
        .commitNextPC      (commitNextPC),
        .faultPropagated   (faultPropagated),
        .unexpectedSyscall (unexpectedSyscall),
        .stqCount          (stqCount),
        .exceptionAck      (exceptionAck),
        .restoreDone       (restoreDone),
        .forceException    (forceException),
        .exceptionPC       (exceptionPC),
        .restoreReq        (restoreReq),
        .stallFetch        (stallFetch),
        .busy              (busy),
        .cause             (cause),
        .recoveryCnt       (recoveryCnt),
        .droppedCnt        (droppedCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: on each rising busy, pop the expected cause/PC
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_trigger got cause=%0d pc=%h, none expected", cause, exceptionPC);
                    end else begin
                        e = exp_q.pop_front();
                        if ({cause, exceptionPC} !== {e.cause, e.pc}) begin
                            errors++;
                            $display("FAIL sb_latch got cause=%0d pc=%h expected cause=%0d pc=%h",
                                     cause, exceptionPC, e.cause, e.pc);
                        end
                    end
                end
                prev_busy = busy;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_commits(input int n, input logic [31:0] pc);
        commitValid  = 1'b1;
        commitNextPC = pc;
        repeat (n) tick();
    endtask

    task automatic complete_recovery;
        int n;
        stqCount     = 5'd0;
        exceptionAck = 1'b1;
        restoreDone  = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        exceptionAck = 1'b0;
        restoreDone  = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL recovery_timeout busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, stallFetch, forceException, restoreReq, cause, exceptionPC, recoveryCnt, droppedCnt} !== 62'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b stall=%b fe=%b rr=%b cause=%0d pc=%h rc=%0d dc=%0d expected all 0",
                     busy, stallFetch, forceException, restoreReq, cause, exceptionPC, recoveryCnt, droppedCnt);
        end
        reset = 1'b0;
        idle_commits(2, 32'h0040_0000);
    endtask

    task automatic test_fault_path;
        int fe;
        int rr;
        idle_commits(2, 32'h0040_0100);
        commitNextPC    = 32'h0040_0120;
        faultPropagated = 1'b1;
        stqCount        = 5'd0;
        exp_q.push_back('{2'd1, 32'h0040_0120});
        tick();
        faultPropagated = 1'b0;
        commitNextPC    = 32'h0040_0124;
        checks++;
        if ({busy, stallFetch, forceException, restoreReq} !== 4'b1100) begin
            errors++;
            $display("FAIL fault_drain_outputs got %b expected 1100", {busy, stallFetch, forceException, restoreReq});
        end
        tick();
        fe = 0;
        rr = 0;
        for (int c = 0; c < 8; c++) begin
            if (forceException) fe++;
            if (restoreReq) rr++;
            exceptionAck = (c == 2);
            restoreDone  = (c == 6);
            tick();
        end
        exceptionAck = 1'b0;
        restoreDone  = 1'b0;
        checks++;
        if (fe != 3) begin
            errors++;
            $display("FAIL fault_force_len got %0d cycles expected 3", fe);
        end
        checks++;
        if (rr != 4) begin
            errors++;
            $display("FAIL fault_restore_len got %0d cycles expected 4", rr);
        end
        checks++;
        if ({busy, stallFetch, cause, recoveryCnt} !== {1'b0, 1'b0, 2'd0, 16'd1}) begin
            errors++;
            $display("FAIL fault_done busy=%b stall=%b cause=%0d rc=%0d expected 0 0 0 1",
                     busy, stallFetch, cause, recoveryCnt);
        end
    endtask

    task automatic test_drain_wait;
        idle_commits(2, 32'h0040_0180);
        commitValid       = 1'b0;
        unexpectedSyscall = 1'b1;
        stqCount          = 5'd3;
        exp_q.push_back('{2'd3, 32'h0040_0180});
        tick();
        unexpectedSyscall = 1'b0;
        commitValid       = 1'b1;
        commitNextPC      = 32'h0040_0184;
        for (int c = 0; c < 3; c++) begin
            stqCount = 5'(2 - c);
            checks++;
            if (forceException !== 1'b0) begin
                errors++;
                $display("FAIL drain_hold step %0d forceException=%b expected 0", c, forceException);
            end
            tick();
        end
        checks++;
        if ({forceException, cause} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL drain_flush fe=%b cause=%0d expected 1 3", forceException, cause);
        end
        complete_recovery();
        checks++;
        if (recoveryCnt !== 16'd2) begin
            errors++;
            $display("FAIL drain_rc got %0d expected 2", recoveryCnt);
        end
        idle_commits(2, 32'h0040_01A0);
    endtask

    task automatic test_watchdog;
        logic early;
        commitValid  = 1'b1;
        commitNextPC = 32'h0040_0200;
        exp_q.push_back('{2'd2, 32'h0040_0200});
        tick();
        commitValid = 1'b0;
        early = 1'b0;
        for (int k = 1; k < 16; k++) begin
            if (busy) early = 1'b1;
            tick();
        end
        checks++;
        if ({early, busy, cause} !== {1'b0, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL wd_fire early=%b busy=%b cause=%0d expected 0 1 2", early, busy, cause);
        end
        complete_recovery();
        commitValid  = 1'b1;
        commitNextPC = 32'h0040_0300;
        tick();
        commitValid = 1'b0;
        repeat (14) tick();
        commitValid = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_prevent busy=%b expected 0", busy);
        end
        idle_commits(3, 32'h0040_0304);
    endtask

    task automatic test_simultaneous;
        commitValid       = 1'b1;
        commitNextPC      = 32'h0040_0500;
        faultPropagated   = 1'b1;
        unexpectedSyscall = 1'b1;
        stqCount          = 5'd5;
        exp_q.push_back('{2'd1, 32'h0040_0500});
        tick();
        unexpectedSyscall = 1'b0;
        repeat (3) tick();
        faultPropagated = 1'b0;
        checks++;
        if ({cause, droppedCnt, exceptionPC} !== {2'd1, 8'd3, 32'h0040_0500}) begin
            errors++;
            $display("FAIL simul got cause=%0d dc=%0d pc=%h expected 1 3 00400500", cause, droppedCnt, exceptionPC);
        end
        complete_recovery();
        idle_commits(2, 32'h0040_0510);
    endtask

    task automatic test_reset_mid;
        commitNextPC    = 32'h0040_0600;
        faultPropagated = 1'b1;
        stqCount        = 5'd0;
        exp_q.push_back('{2'd1, 32'h0040_0600});
        tick();
        faultPropagated = 1'b0;
        tick();
        checks++;
        if (forceException !== 1'b1) begin
            errors++;
            $display("FAIL rmid_in_flush forceException=%b expected 1", forceException);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, stallFetch, forceException, restoreReq, cause, exceptionPC, recoveryCnt, droppedCnt} !== 62'd0) begin
            errors++;
            $display("FAIL rmid_outputs busy=%b stall=%b fe=%b rr=%b cause=%0d pc=%h rc=%0d dc=%0d expected all 0",
                     busy, stallFetch, forceException, restoreReq, cause, exceptionPC, recoveryCnt, droppedCnt);
        end
        exceptionAck = 1'b1;
        tick();
        exceptionAck = 1'b0;
        checks++;
        if ({busy, stallFetch, forceException, restoreReq} !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_spurious_ack got %b expected 0000", {busy, stallFetch, forceException, restoreReq});
        end
        idle_commits(2, 32'h0040_0610);
    endtask

    task automatic test_saturation;
        commitNextPC    = 32'h0040_0700;
        faultPropagated = 1'b1;
        stqCount        = 5'd1;
        exp_q.push_back('{2'd1, 32'h0040_0700});
        tick();
        repeat (100) tick();
        checks++;
        if (droppedCnt !== 8'd100) begin
            errors++;
            $display("FAIL sat_mid got %0d expected 100", droppedCnt);
        end
        repeat (160) tick();
        faultPropagated = 1'b0;
        checks++;
        if (droppedCnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold got %0d expected 255", droppedCnt);
        end
        complete_recovery();
        checks++;
        if ({recoveryCnt, droppedCnt} !== {16'd1, 8'd255}) begin
            errors++;
            $display("FAIL sat_after rc=%0d dc=%0d expected 1 255", recoveryCnt, droppedCnt);
        end
        idle_commits(2, 32'h0040_0710);
    endtask

    initial begin
        reset             = 1'b1;
        commitValid       = 1'b0;
        commitNextPC      = 32'h0;
        faultPropagated   = 1'b0;
        unexpectedSyscall = 1'b0;
        stqCount          = 5'd0;
        exceptionAck      = 1'b0;
        restoreDone       = 1'b0;

        test_reset();
        test_fault_path();
        test_drain_wait();
        test_watchdog();
        test_simultaneous();
        test_reset_mid();
        test_saturation();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover %0d expected triggers never seen, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
